// File: rtl/resize_mul_pipe.sv
// Pipelined signed/unsigned multiplier with post-shift and resize, valid/ready handshake.
// Optional saturation of narrowed results is enabled with `define RESIZE_MUL_PIPE_SAT_EN.
module resize_mul_pipe #(
  parameter int unsigned din0_WIDTH = 16,
  parameter int unsigned din1_WIDTH = 16,
  parameter int unsigned dout_WIDTH = 32,
  parameter int unsigned NUM_STAGE  = 3,
  parameter int unsigned SHIFT      = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  is_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  sat_flag
);

  localparam int unsigned PW = din0_WIDTH + din1_WIDTH;

  // Low PW bits of the product of PW-bit extended operands equal the exact product.
  function automatic logic [PW-1:0] mul_ext(input logic [din0_WIDTH-1:0] a,
                                            input logic [din1_WIDTH-1:0] b,
                                            input logic                  sgn);
    logic [PW-1:0] ax;
    logic [PW-1:0] bx;
    ax = {{din1_WIDTH{sgn & a[din0_WIDTH-1]}}, a};
    bx = {{din0_WIDTH{sgn & b[din1_WIDTH-1]}}, b};
    return ax * bx;
  endfunction

  logic                  advance;
  logic [NUM_STAGE-1:0]  valid_q;
  logic [PW-1:0]         fin_p;
  logic                  fin_s;
  logic [PW-1:0]         shifted;
  logic [dout_WIDTH-1:0] res_d;
  logic [dout_WIDTH-1:0] dout_q;

  // Global stall: every stage moves together, bubbles included.
  assign advance   = ~out_valid | out_ready;
  assign in_ready  = advance;
  assign out_valid = valid_q[NUM_STAGE-1];
  assign dout      = dout_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      valid_q <= '0;
    end else if (advance) begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < NUM_STAGE; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Payload stages feeding the output register.
  generate
    if (NUM_STAGE == 1) begin : g_direct
      assign fin_p = mul_ext(din0, din1, is_signed);
      assign fin_s = is_signed;
    end else begin : g_staged
      logic [din0_WIDTH-1:0] a_q;
      logic [din1_WIDTH-1:0] b_q;
      logic                  s0_q;

      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          a_q  <= '0;
          b_q  <= '0;
          s0_q <= 1'b0;
        end else if (advance) begin
          a_q  <= din0;
          b_q  <= din1;
          s0_q <= is_signed;
        end
      end

      if (NUM_STAGE == 2) begin : g_two
        assign fin_p = mul_ext(a_q, b_q, s0_q);
        assign fin_s = s0_q;
      end else begin : g_deep
        localparam int unsigned ND = NUM_STAGE - 2;
        logic [PW-1:0] prod_q [ND];
        logic [ND-1:0] sgn_q;

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
          if (!ap_rst_n) begin
            for (int i = 0; i < ND; i++) begin
              prod_q[i] <= '0;
            end
            sgn_q <= '0;
          end else if (advance) begin
            prod_q[0] <= mul_ext(a_q, b_q, s0_q);
            sgn_q[0]  <= s0_q;
            for (int i = 1; i < ND; i++) begin
              prod_q[i] <= prod_q[i-1];
              sgn_q[i]  <= sgn_q[i-1];
            end
          end
        end

        assign fin_p = prod_q[ND-1];
        assign fin_s = sgn_q[ND-1];
      end
    end
  endgenerate

  always_comb begin
    if (fin_s) begin
      shifted = PW'($signed(fin_p) >>> SHIFT);
    end else begin
      shifted = fin_p >> SHIFT;
    end
  end

`ifdef RESIZE_MUL_PIPE_SAT_EN
  logic sat_d;
  logic sat_q;
  assign sat_flag = sat_q;
`else
  assign sat_flag = 1'b0;
`endif

  generate
    if (dout_WIDTH > PW) begin : g_widen
      assign res_d = {{(dout_WIDTH - PW){fin_s & shifted[PW-1]}}, shifted};
`ifdef RESIZE_MUL_PIPE_SAT_EN
      assign sat_d = 1'b0;
`endif
    end else if (dout_WIDTH == PW) begin : g_same
      assign res_d = shifted;
`ifdef RESIZE_MUL_PIPE_SAT_EN
      assign sat_d = 1'b0;
`endif
    end else begin : g_narrow
      logic [dout_WIDTH-1:0] trunc;
      assign trunc = dout_WIDTH'(shifted);
`ifdef RESIZE_MUL_PIPE_SAT_EN
      localparam logic [dout_WIDTH-1:0] SignedMin = dout_WIDTH'(1) << (dout_WIDTH - 1);
      // Dropped bits plus the kept sign bit: must all match for a signed fit.
      logic [PW-dout_WIDTH:0] hi_bits;
      logic                   ovf;
      assign hi_bits = shifted[PW-1:dout_WIDTH-1];

      always_comb begin
        ovf   = 1'b0;
        res_d = trunc;
        if (fin_s) begin
          ovf = ~((&hi_bits) | ~(|hi_bits));
          if (ovf) begin
            res_d = hi_bits[PW-dout_WIDTH] ? SignedMin : ~SignedMin;
          end
        end else begin
          ovf = |hi_bits[PW-dout_WIDTH:1];
          if (ovf) begin
            res_d = '1;
          end
        end
      end
      assign sat_d = ovf;
`else
      assign res_d = trunc;
`endif
    end
  endgenerate

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dout_q <= '0;
    end else if (advance) begin
      dout_q <= res_d;
    end
  end

`ifdef RESIZE_MUL_PIPE_SAT_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      sat_q <= 1'b0;
    end else if (advance) begin
      sat_q <= sat_d;
    end
  end
`endif

endmodule

// File: tb/tb_resize_mul_pipe.sv
// Bench for resize_mul_pipe: three instances (default, 16-bit output, single-stage with shift).
// Expected values follow RESIZE_MUL_PIPE_SAT_EN when it is defined for the build.
module tb_resize_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] din0;
  logic [15:0] din1;
  logic        sgn;
  logic        out_ready;
  logic [2:0]  iv;
  logic [2:0]  ir;
  logic [2:0]  ov;
  logic [2:0]  sf;
  logic [31:0] d0;
  logic [15:0] d1;
  logic [31:0] d2;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  resize_mul_pipe u_def (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .din0(din0),
    .din1(din1), .is_signed(sgn), .out_valid(ov[0]), .out_ready(out_ready), .dout(d0),
    .sat_flag(sf[0])
  );

  resize_mul_pipe #(.dout_WIDTH(16)) u_nar (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .din0(din0),
    .din1(din1), .is_signed(sgn), .out_valid(ov[1]), .out_ready(out_ready), .dout(d1),
    .sat_flag(sf[1])
  );

  resize_mul_pipe #(.NUM_STAGE(1), .SHIFT(4)) u_ns1 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .din0(din0),
    .din1(din1), .is_signed(sgn), .out_valid(ov[2]), .out_ready(out_ready), .dout(d2),
    .sat_flag(sf[2])
  );

  typedef struct {
    int          d;
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [31:0] exp;
    logic        sat;
  } vec_t;

  vec_t tbl[13];

  function automatic logic [31:0] dout_of(input int d);
    case (d)
      0:       return d0;
      1:       return {16'h0, d1};
      default: return d2;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int d, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [31:0] exp, input logic sat,
                         input string nm);
    int lat;
    int lat_exp;
    lat_exp = (d == 2) ? 0 : 2;
    @(negedge clk);
    out_ready = 1'b1;
    din0 = a;
    din1 = b;
    sgn = s;
    iv[d] = 1'b1;
    #1;
    chk({nm, "_in_ready"}, 64'(ir[d]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    iv[d] = 1'b0;
    #1;
    lat = 0;
    while (!ov[d] && lat < 8) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'(lat_exp));
    chk({nm, "_dout"}, 64'(dout_of(d)), 64'(exp));
    chk({nm, "_sat"}, 64'(sf[d]), 64'(sat));
  endtask

  task automatic bp_test();
    logic [31:0] exp_q[$];
    int idx;
    int recv;
    int stall;
    int extra;
    idx = 0;
    recv = 0;
    stall = -1;
    extra = 0;
    for (int i = 1; i <= 5; i++) exp_q.push_back(32'(i * i));
    sgn = 1'b0;
    for (int n = 0; n < 40 && recv < 5; n++) begin
      @(negedge clk);
      #1;
      if (ov[0] && stall < 0) stall = 4;
      out_ready = !(stall > 0);
      iv[0] = (idx < 5);
      din0 = 16'(idx + 1);
      din1 = 16'(idx + 1);
      #1;
      if (stall > 0) begin
        chk("bp_in_ready_low", 64'(ir[0]), 64'd0);
        chk("bp_dout_hold", 64'(d0), 64'd1);
        stall--;
      end
      if (ov[0] && out_ready) begin
        chk($sformatf("bp_out%0d", recv), 64'(d0), 64'(exp_q[recv]));
        recv++;
      end
      if (iv[0] && ir[0]) idx++;
    end
    iv[0] = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", 64'(recv), 64'd5);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      #1;
      if (ov[0]) extra++;
    end
    chk("bp_no_dup", 64'(extra), 64'd0);
  endtask

  task automatic reset_test();
    int stale;
    stale = 0;
    out_ready = 1'b1;
    sgn = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      iv[0] = 1'b1;
      din0 = 16'(i);
      din1 = 16'd2;
    end
    @(negedge clk);
    iv[0] = 1'b0;
    #1;
    chk("rst_pre_valid", 64'(ov[0]), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 64'(ov[0]), 64'd0);
    chk("rst_async_dout", 64'(d0), 64'd0);
    chk("rst_in_ready", 64'(ir[0]), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      #1;
      if (ov[0]) stale++;
    end
    chk("rst_no_stale", 64'(stale), 64'd0);
    run_vec(0, 16'd3, 16'd7, 1'b0, 32'd21, 1'b0, "rst_new");
  endtask

  task automatic stream_test();
    logic [15:0] a[5];
    logic [15:0] b[5];
    logic        s[5];
    logic [31:0] e[5];
    a = '{16'h0010, 16'h0100, 16'hFFF0, 16'hFFF0, 16'h8000};
    b = '{16'h0003, 16'h0100, 16'h0001, 16'h0001, 16'h8000};
    s = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    e = '{32'h00000003, 32'h00001000, 32'hFFFFFFFF, 32'h00000FFF, 32'h04000000};
    out_ready = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      #1;
      if (i > 0) begin
        chk($sformatf("ns1_valid%0d", i - 1), 64'(ov[2]), 64'd1);
        chk($sformatf("ns1_dout%0d", i - 1), 64'(d2), 64'(e[i-1]));
      end
      if (i < 5) begin
        din0 = a[i];
        din1 = b[i];
        sgn = s[i];
        iv[2] = 1'b1;
        #1;
        chk($sformatf("ns1_ready%0d", i), 64'(ir[2]), 64'd1);
      end else begin
        iv[2] = 1'b0;
      end
    end
    @(negedge clk);
    #1;
    chk("ns1_drain", 64'(ov[2]), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    iv = '0;
    din0 = '0;
    din1 = '0;
    sgn = 1'b0;
    out_ready = 1'b1;

    tbl[0]  = '{0, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 1'b0};
    tbl[1]  = '{0, 16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, 1'b0};
    tbl[2]  = '{0, 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 1'b0};
    tbl[3]  = '{0, 16'h8000, 16'h7FFF, 1'b0, 32'h3FFF8000, 1'b0};
    tbl[4]  = '{0, 16'h0000, 16'h1234, 1'b0, 32'h00000000, 1'b0};
    tbl[5]  = '{0, 16'h0003, 16'hFFFE, 1'b1, 32'hFFFFFFFA, 1'b0};
    tbl[6]  = '{0, 16'h1234, 16'h0010, 1'b0, 32'h00012340, 1'b0};
`ifdef RESIZE_MUL_PIPE_SAT_EN
    tbl[7]  = '{1, 16'h0100, 16'h0100, 1'b0, 32'h0000FFFF, 1'b1};
    tbl[8]  = '{1, 16'hFF00, 16'h0100, 1'b1, 32'h00008000, 1'b1};
    tbl[9]  = '{1, 16'h0100, 16'h0080, 1'b1, 32'h00007FFF, 1'b1};
`else
    tbl[7]  = '{1, 16'h0100, 16'h0100, 1'b0, 32'h00000000, 1'b0};
    tbl[8]  = '{1, 16'hFF00, 16'h0100, 1'b1, 32'h00000000, 1'b0};
    tbl[9]  = '{1, 16'h0100, 16'h0080, 1'b1, 32'h00008000, 1'b0};
`endif
    tbl[10] = '{1, 16'h00FF, 16'h0100, 1'b0, 32'h0000FF00, 1'b0};
    tbl[11] = '{1, 16'hFFFF, 16'h0005, 1'b1, 32'h0000FFFB, 1'b0};
    tbl[12] = '{1, 16'hFFFF, 16'h0001, 1'b0, 32'h0000FFFF, 1'b0};

    #3;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_valid%0d", d), 64'(ov[d]), 64'd0);
      chk($sformatf("reset_ready%0d", d), 64'(ir[d]), 64'd1);
      chk($sformatf("reset_dout%0d", d), 64'(dout_of(d)), 64'd0);
      chk($sformatf("reset_sat%0d", d), 64'(sf[d]), 64'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_vec(tbl[i].d, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].exp, tbl[i].sat,
              $sformatf("vec%0d", i));
    end

    bp_test();
    reset_test();
    stream_test();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
